// File: rtl/arith_encoder_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : arith_encoder_scheduler
// Purpose  : Two-requester scheduler in front of an arithmetic encoder.
//            Opens a frame on start, resets the encoder for two cycles,
//            grants symbols round-robin, registers the winning bundle onto
//            enc_*, tracks which requester owns each symbol through the
//            encoder pipeline, and drains the pipeline after flush.
// Ports    : general_clk / reset (async, active-low)
//            start, flush           frame open / close pulses
//            req_* (x2, packed)     per-requester symbol bundles
//            req_ready (x2)         combinational one-hot grant
//            enc_reset, enc_valid, enc_fl/fh/symbol/nsyms/bool  to encoder
//            out_valid, out_owner   owner tag aligned with encoder output
//            busy, done, sym_count  frame status
// Revision : 1.0 - initial release
// ============================================================================
module arith_encoder_scheduler #(
    parameter int GENERAL_RANGE_WIDTH  = 16,
    parameter int GENERAL_SYMBOL_WIDTH = 4,
    parameter int PIPE_DEPTH           = 3
) (
    input  logic                                general_clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                flush,
    input  logic [1:0]                          req_valid,
    output logic [1:0]                          req_ready,
    input  logic [2*GENERAL_RANGE_WIDTH-1:0]    req_fl,
    input  logic [2*GENERAL_RANGE_WIDTH-1:0]    req_fh,
    input  logic [2*GENERAL_SYMBOL_WIDTH-1:0]   req_symbol,
    input  logic [2*(GENERAL_SYMBOL_WIDTH+1)-1:0] req_nsyms,
    input  logic [1:0]                          req_bool,
    output logic                                enc_reset,
    output logic                                enc_valid,
    output logic [GENERAL_RANGE_WIDTH-1:0]      enc_fl,
    output logic [GENERAL_RANGE_WIDTH-1:0]      enc_fh,
    output logic [GENERAL_SYMBOL_WIDTH-1:0]     enc_symbol,
    output logic [GENERAL_SYMBOL_WIDTH:0]       enc_nsyms,
    output logic                                enc_bool,
    output logic                                out_valid,
    output logic                                out_owner,
    output logic                                busy,
    output logic                                done,
    output logic [15:0]                         sym_count
);

    localparam int RW = GENERAL_RANGE_WIDTH;
    localparam int SW = GENERAL_SYMBOL_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   init_cnt_q;     // second INIT cycle marker
    logic                   init_done_q;    // first INIT since reset completed
    logic                   last_q;         // requester of most recent transfer
    logic                   enc_valid_q;
    logic                   enc_owner_q;
    logic [RW-1:0]          enc_fl_q, enc_fh_q;
    logic [SW-1:0]          enc_symbol_q;
    logic [SW:0]            enc_nsyms_q;
    logic                   enc_bool_q;
    logic [PIPE_DEPTH-1:0]  pipe_valid_q;
    logic [PIPE_DEPTH-1:0]  pipe_owner_q;
    logic [15:0]            sym_count_q;

    logic                   xfer;
    logic                   sel;

    // Next state and grant. A tie goes to whoever did not win last time;
    // last_q is preset to 1 so requester 0 wins the first tie of a frame.
    always_comb begin
        state_d   = state_q;
        req_ready = 2'b00;
        case (state_q)
            S_IDLE:  if (start) state_d = S_INIT;
            S_INIT:  if (init_cnt_q) state_d = S_RUN;
            S_RUN: begin
                if (flush) begin
                    state_d = S_DRAIN;
                end else if (req_valid == 2'b11) begin
                    req_ready = last_q ? 2'b01 : 2'b10;
                end else begin
                    req_ready = req_valid;
                end
            end
            S_DRAIN: if (!enc_valid_q && (pipe_valid_q == '0)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign xfer = |(req_valid & req_ready);
    assign sel  = req_ready[1];

    always_ff @(posedge general_clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            init_cnt_q   <= 1'b0;
            init_done_q  <= 1'b0;
            last_q       <= 1'b1;
            enc_valid_q  <= 1'b0;
            enc_owner_q  <= 1'b0;
            enc_fl_q     <= '0;
            enc_fh_q     <= '0;
            enc_symbol_q <= '0;
            enc_nsyms_q  <= '0;
            enc_bool_q   <= 1'b0;
            pipe_valid_q <= '0;
            pipe_owner_q <= '0;
            sym_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= (state_q == S_INIT) ? ~init_cnt_q : 1'b0;
            if ((state_q == S_INIT) && init_cnt_q) begin
                init_done_q <= 1'b1;
            end

            enc_valid_q <= xfer;
            if (xfer) begin
                enc_owner_q  <= sel;
                last_q       <= sel;
                enc_fl_q     <= req_fl[sel*RW +: RW];
                enc_fh_q     <= req_fh[sel*RW +: RW];
                enc_symbol_q <= req_symbol[sel*SW +: SW];
                enc_nsyms_q  <= req_nsyms[sel*(SW+1) +: (SW+1)];
                enc_bool_q   <= req_bool[sel];
            end

            // Owner tags follow the encoder latency one stage per cycle.
            pipe_valid_q[0] <= enc_valid_q;
            pipe_owner_q[0] <= enc_owner_q;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_owner_q[i] <= pipe_owner_q[i-1];
            end

            if ((state_q == S_IDLE) && start) begin
                sym_count_q <= '0;
                last_q      <= 1'b1;
            end else if (xfer && (sym_count_q != 16'hFFFF)) begin
                sym_count_q <= sym_count_q + 16'd1;
            end
        end
    end

    // Encoder is held in reset from reset until the first INIT finishes,
    // and again during every INIT.
    assign enc_reset  = (state_q == S_INIT) || ((state_q == S_IDLE) && !init_done_q);
    assign enc_valid  = enc_valid_q;
    assign enc_fl     = enc_fl_q;
    assign enc_fh     = enc_fh_q;
    assign enc_symbol = enc_symbol_q;
    assign enc_nsyms  = enc_nsyms_q;
    assign enc_bool   = enc_bool_q;
    assign out_valid  = pipe_valid_q[PIPE_DEPTH-1];
    assign out_owner  = pipe_owner_q[PIPE_DEPTH-1];
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign sym_count  = sym_count_q;

endmodule
`default_nettype wire

// File: tb/tb_arith_encoder_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_arith_encoder_scheduler
// Purpose  : Self-checking bench for arith_encoder_scheduler. A frame-level
//            reference model (phase, tie memory, queue of owner tags with
//            due cycles) predicts every output each cycle; directed
//            sequences pin literal values for init, arbitration, a single
//            transfer, flush collision, reset mid-drain and saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arith_encoder_scheduler;

    localparam int RW = 16;
    localparam int SW = 4;
    localparam int D  = 3;

    localparam int P_IDLE  = 0;
    localparam int P_INIT  = 1;
    localparam int P_RUN   = 2;
    localparam int P_DRAIN = 3;
    localparam int P_DONE  = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic                  flush = 1'b0;
    logic [1:0]            req_valid = '0;
    logic [1:0]            req_ready;
    logic [2*RW-1:0]       req_fl = '0;
    logic [2*RW-1:0]       req_fh = '0;
    logic [2*SW-1:0]       req_symbol = '0;
    logic [2*(SW+1)-1:0]   req_nsyms = '0;
    logic [1:0]            req_bool = '0;
    logic                  enc_reset, enc_valid, enc_bool;
    logic [RW-1:0]         enc_fl, enc_fh;
    logic [SW-1:0]         enc_symbol;
    logic [SW:0]           enc_nsyms;
    logic                  out_valid, out_owner, busy, done;
    logic [15:0]           sym_count;

    int n_cmp = 0;
    int n_bad = 0;

    arith_encoder_scheduler #(
        .GENERAL_RANGE_WIDTH (RW),
        .GENERAL_SYMBOL_WIDTH(SW),
        .PIPE_DEPTH          (D)
    ) dut (
        .general_clk(clk),
        .reset      (rst_n),
        .start      (start),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_fl     (req_fl),
        .req_fh     (req_fh),
        .req_symbol (req_symbol),
        .req_nsyms  (req_nsyms),
        .req_bool   (req_bool),
        .enc_reset  (enc_reset),
        .enc_valid  (enc_valid),
        .enc_fl     (enc_fl),
        .enc_fh     (enc_fh),
        .enc_symbol (enc_symbol),
        .enc_nsyms  (enc_nsyms),
        .enc_bool   (enc_bool),
        .out_valid  (out_valid),
        .out_owner  (out_owner),
        .busy       (busy),
        .done       (done),
        .sym_count  (sym_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int owner;
        int due;
    } tag_t;

    tag_t            tagq[$];
    int              cyc       = 0;
    int              ph        = P_IDLE;
    int              init_left = 0;
    int              m_last    = 1;
    bit              m_seen    = 1'b0;
    int              m_count   = 0;
    bit              m_ev      = 1'b0;
    logic [RW-1:0]   m_fl = '0, m_fh = '0;
    logic [SW-1:0]   m_sym = '0;
    logic [SW:0]     m_ns = '0;
    logic            m_bool = 1'b0;

    function automatic logic [1:0] exp_ready();
        if (ph != P_RUN || flush) return 2'b00;
        if (req_valid == 2'b11) return (m_last == 1) ? 2'b01 : 2'b10;
        return req_valid;
    endfunction

    function automatic bit exp_out_valid();
        return (tagq.size() > 0) && (tagq[0].due == cyc);
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            tagq.delete();
            ph = P_IDLE; m_last = 1; m_seen = 1'b0; m_count = 0; m_ev = 1'b0;
            m_fl = '0; m_fh = '0; m_sym = '0; m_ns = '0; m_bool = 1'b0;
        end else begin
            logic [1:0] g;
            bit         empty_now;
            g         = exp_ready() & req_valid;
            empty_now = (tagq.size() == 0);
            if (exp_out_valid()) void'(tagq.pop_front());
            m_ev = 1'b0;
            if (g != 2'b00) begin
                int r;
                r      = g[1] ? 1 : 0;
                m_ev   = 1'b1;
                m_fl   = req_fl[r*RW +: RW];
                m_fh   = req_fh[r*RW +: RW];
                m_sym  = req_symbol[r*SW +: SW];
                m_ns   = req_nsyms[r*(SW+1) +: (SW+1)];
                m_bool = req_bool[r];
                m_last = r;
                tagq.push_back('{owner: r, due: cyc + 1 + D});
                if (m_count < 65535) m_count++;
            end
            case (ph)
                P_IDLE:  if (start) begin ph = P_INIT; init_left = 2; m_count = 0; m_last = 1; end
                P_INIT:  begin
                             init_left--;
                             if (init_left == 0) begin ph = P_RUN; m_seen = 1'b1; end
                         end
                P_RUN:   if (flush) ph = P_DRAIN;
                P_DRAIN: if (empty_now) ph = P_DONE;
                default: ph = P_IDLE;
            endcase
        end
        cyc++;
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        bit eov;
        @(negedge clk);
        #2;
        eov = exp_out_valid();
        chk("req_ready",  {62'd0, req_ready}, {62'd0, exp_ready()});
        chk("enc_valid",  {63'd0, enc_valid}, {63'd0, m_ev});
        chk("enc_fl",     {48'd0, enc_fl}, {48'd0, m_fl});
        chk("enc_fh",     {48'd0, enc_fh}, {48'd0, m_fh});
        chk("enc_symbol", {60'd0, enc_symbol}, {60'd0, m_sym});
        chk("enc_nsyms",  {59'd0, enc_nsyms}, {59'd0, m_ns});
        chk("enc_bool",   {63'd0, enc_bool}, {63'd0, m_bool});
        chk("out_valid",  {63'd0, out_valid}, {63'd0, eov});
        if (eov)
            chk("out_owner", {63'd0, out_owner}, 64'(tagq[0].owner));
        else if (!rst_n)
            chk("out_owner_rst", {63'd0, out_owner}, 64'd0);
        chk("busy",       {63'd0, busy}, {63'd0, (ph != P_IDLE)});
        chk("done",       {63'd0, done}, {63'd0, (ph == P_DONE)});
        chk("sym_count",  {48'd0, sym_count}, 64'(m_count));
        chk("enc_reset",  {63'd0, enc_reset},
            {63'd0, (ph == P_INIT) || (ph == P_IDLE && !m_seen)});
    end

    // ---------------- stimulus helpers ----------------
    task automatic rand_bundle();
        req_fl     = 32'($urandom);
        req_fh     = 32'($urandom);
        req_symbol = 8'($urandom);
        req_nsyms  = 10'($urandom);
        req_bool   = 2'($urandom);
    endtask

    task automatic go_idle();
        @(negedge clk);
        req_valid = 2'b00; start = 1'b0; flush = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        flush = 1'b0;
        chk("idle_reached", {63'd0, busy}, 64'd0);
    endtask

    // Returns at the negedge opening the first RUN cycle.
    task automatic start_frame();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [1:0] rdy [12];
        logic       ov  [12];
        logic       oo  [12];
        int         done_cnt, done_at;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #3;
        chk("post_reset_enc_reset", {63'd0, enc_reset}, 64'd1);
        chk("post_reset_sym_count", {48'd0, sym_count}, 64'd0);

        // Init timing: start at cycle 0.
        @(negedge clk); start = 1'b1; #3;
        chk("c0_busy", {63'd0, busy}, 64'd0);
        @(negedge clk); start = 1'b0; #3;
        chk("c1_busy", {63'd0, busy}, 64'd1);
        chk("c1_enc_reset", {63'd0, enc_reset}, 64'd1);
        @(negedge clk); req_valid = 2'b11; rand_bundle(); #3;
        chk("c2_enc_reset", {63'd0, enc_reset}, 64'd1);
        chk("c2_ready", {62'd0, req_ready}, 64'd0);

        // Arbitration: both valid for 6 cycles from cycle 3.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            req_valid = (i < 6) ? 2'b11 : 2'b00;
            rand_bundle();
            #3;
            rdy[i] = req_ready; ov[i] = out_valid; oo[i] = out_owner;
            if (i == 0) chk("c3_enc_reset", {63'd0, enc_reset}, 64'd0);
        end
        for (int i = 0; i < 4; i++)
            chk("arb_early_out", {63'd0, ov[i]}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            chk("arb_grant", {62'd0, rdy[i]}, (i % 2 == 0) ? 64'd1 : 64'd2);
            chk("arb_out_valid", {63'd0, ov[i+4]}, 64'd1);
            chk("arb_out_owner", {63'd0, oo[i+4]}, 64'(i % 2));
        end

        // Single requester 1 with fixed bundle.
        @(negedge clk);
        req_valid = 2'b10;
        req_fl[31:16] = 16'd100; req_fh[31:16] = 16'd200;
        req_symbol[7:4] = 4'd5; req_nsyms[9:5] = 5'd8; req_bool[1] = 1'b1;
        @(negedge clk); req_valid = 2'b00; #3;
        chk("single_enc_valid", {63'd0, enc_valid}, 64'd1);
        chk("single_enc_fl", {48'd0, enc_fl}, 64'd100);
        chk("single_enc_fh", {48'd0, enc_fh}, 64'd200);
        chk("single_enc_symbol", {60'd0, enc_symbol}, 64'd5);
        chk("single_enc_nsyms", {59'd0, enc_nsyms}, 64'd8);
        repeat (3) @(negedge clk);
        #3;
        chk("single_out_valid", {63'd0, out_valid}, 64'd1);
        chk("single_out_owner", {63'd0, out_owner}, 64'd1);
        chk("single_sym_count", {48'd0, sym_count}, 64'd7);

        // Random traffic with sporadic start/flush.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            req_valid = 2'($urandom);
            flush     = ($urandom_range(0, 29) == 0);
            start     = ($urandom_range(0, 19) == 0);
            rand_bundle();
        end

        // Flush colliding with a request.
        go_idle();
        start_frame();
        req_valid = 2'b10; rand_bundle();
        @(negedge clk); req_valid = 2'b01; flush = 1'b1; #3;
        chk("collide_ready", {62'd0, req_ready}, 64'd0);
        @(negedge clk); req_valid = 2'b00; flush = 1'b0;
        done_cnt = 0; done_at = -1;
        for (int k = 2; k < 14; k++) begin
            #3;
            if (done) begin done_cnt++; done_at = k; end
            @(negedge clk);
        end
        chk("collide_done_pulses", 64'(done_cnt), 64'd1);
        chk("collide_done_cycle", 64'(done_at), 64'd6);
        chk("collide_sym_count", {48'd0, sym_count}, 64'd1);

        // Reset during DRAIN with two tags in flight.
        go_idle();
        start_frame();
        req_valid = 2'b11; rand_bundle();
        @(negedge clk); req_valid = 2'b11; rand_bundle();
        @(negedge clk); req_valid = 2'b00; flush = 1'b1;
        @(negedge clk); flush = 1'b0; #3;
        chk("drain_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0; #3;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_enc_reset", {63'd0, enc_reset}, 64'd1);
        chk("mid_rst_sym_count", {48'd0, sym_count}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #3;
            chk("post_rst_no_done", {63'd0, done}, 64'd0);
            chk("post_rst_no_out", {63'd0, out_valid}, 64'd0);
        end

        // Saturation.
        start_frame();
        req_valid = 2'b01;
        repeat (65540) @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk); #3;
        chk("sat_count", {48'd0, sym_count}, 64'hFFFF);
        go_idle();
        chk("sat_hold_idle", {48'd0, sym_count}, 64'hFFFF);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; #3;
        chk("sat_clear_on_start", {48'd0, sym_count}, 64'd0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
